// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row debounce, key commit and 4-digit entry shift register.
// Latency: rows synchronized over 2 cycles; a press commits one cycle after its DEBOUNCE-th matching sample point.
// Backpressure: none; key_valid is a fire-and-forget pulse, entry_clr is honoured on any cycle.
module keypad_scan #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic        CLK,
  input  logic        clr,
  input  logic [3:0]  row_in,
  input  logic        entry_clr,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] entry_data
);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HOLD     = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_N    = 4'(DEBOUNCE);

  // State registers and their next values
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  rows_s_q, rows_s_d;
  logic [7:0]  div_q, div_d;
  state_t      state_q, state_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [3:0]  deb_cnt_q, deb_cnt_d;
  logic [3:0]  rel_cnt_q, rel_cnt_d;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  key_code_q, key_code_d;
  logic [15:0] entry_data_q, entry_data_d;

  // Combinational helpers
  logic        sample;
  logic        one_low;
  logic [1:0]  low_idx;
  logic        commit;
  logic [3:0]  code;

  // Row decode: a valid single key pulls exactly one row line low
  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    case (rows_s_q)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // Synchronizer, dwell divider and scan/debounce/hold state machine
  always_comb begin
    sync1_d   = row_in;
    rows_s_d  = sync1_q;
    sample    = (div_q == DIV_LAST);
    div_d     = sample ? 8'd0 : div_q + 8'd1;
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    deb_cnt_d = deb_cnt_q;
    rel_cnt_d = rel_cnt_q;
    commit    = 1'b0;

    if (sample) begin
      case (state_q)
        S_SCAN: begin
          if (one_low) begin
            row_idx_d = low_idx;
            deb_cnt_d = 4'd1;
            if (DEB_N == 4'd1) begin
              commit    = 1'b1;
              state_d   = S_HOLD;
              rel_cnt_d = 4'd0;
            end else begin
              state_d = S_DEBOUNCE;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (one_low && (low_idx == row_idx_q)) begin
            deb_cnt_d = deb_cnt_q + 4'd1;
            if ((deb_cnt_q + 4'd1) == DEB_N) begin
              commit    = 1'b1;
              state_d   = S_HOLD;
              rel_cnt_d = 4'd0;
            end
          end else begin
            state_d   = S_SCAN;
            col_idx_d = col_idx_q + 2'd1;
            deb_cnt_d = 4'd0;
          end
        end
        S_HOLD: begin
          // Any low row, including a second key, restarts the release count
          if (rows_s_q == 4'hF) begin
            if ((rel_cnt_q + 4'd1) == DEB_N) begin
              state_d   = S_SCAN;
              col_idx_d = col_idx_q + 2'd1;
              rel_cnt_d = 4'd0;
            end else begin
              rel_cnt_d = rel_cnt_q + 4'd1;
            end
          end else begin
            rel_cnt_d = 4'd0;
          end
        end
        default: begin
          state_d = S_SCAN;
        end
      endcase
    end
  end

  // Commit outputs: pulse, last code and entry shift register (clear wins over shift-in history)
  always_comb begin
    code         = {row_idx_d, col_idx_q};
    key_valid_d  = commit;
    key_code_d   = commit ? code : key_code_q;
    entry_data_d = entry_data_q;
    if (entry_clr) begin
      entry_data_d = commit ? {12'h000, code} : 16'h0000;
    end else if (commit) begin
      entry_data_d = {entry_data_q[11:0], code};
    end
  end

  // Register update with synchronous reset
  always_ff @(posedge CLK) begin
    if (clr) begin
      sync1_q      <= 4'hF;
      rows_s_q     <= 4'hF;
      div_q        <= 8'd0;
      state_q      <= S_SCAN;
      col_idx_q    <= 2'd0;
      row_idx_q    <= 2'd0;
      deb_cnt_q    <= 4'd0;
      rel_cnt_q    <= 4'd0;
      key_valid_q  <= 1'b0;
      key_code_q   <= 4'h0;
      entry_data_q <= 16'h0000;
    end else begin
      sync1_q      <= sync1_d;
      rows_s_q     <= rows_s_d;
      div_q        <= div_d;
      state_q      <= state_d;
      col_idx_q    <= col_idx_d;
      row_idx_q    <= row_idx_d;
      deb_cnt_q    <= deb_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      entry_data_q <= entry_data_d;
    end
  end

  assign col_out    = ~(4'b0001 << col_idx_q);
  assign key_valid  = key_valid_q;
  assign key_code   = key_code_q;
  assign entry_data = entry_data_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad matrix model drives row_in from col_out and a set of pressed keys.
// Each commit is predicted into a queue and checked when key_valid fires.
module tb_keypad_scan;

  localparam int SCAN_DIV    = 16;
  localparam int DEBOUNCE    = 4;
  localparam int COMMIT_WAIT = SCAN_DIV * DEBOUNCE - 1;
  localparam int NVEC        = 12;

  logic        CLK;
  logic        clr;
  logic [3:0]  row_in;
  logic        entry_clr;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry_data;

  logic [15:0] pressed;
  int total  = 0;
  int bad    = 0;
  int pulses = 0;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] entry;
  } sb_t;
  sb_t sbq[$];
  sb_t mon_e;

  typedef struct {
    logic [3:0]  code;
    logic        do_clr;
    logic [15:0] extra;
    logic [15:0] exp_entry;
  } vec_t;
  vec_t vecs[NVEC];

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .CLK        (CLK),
    .clr        (clr),
    .row_in     (row_in),
    .entry_clr  (entry_clr),
    .col_out    (col_out),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .entry_data (entry_data)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Keypad matrix: a pressed key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every key_valid pulse must match the oldest predicted commit
  always @(negedge CLK) begin
    if (!clr && key_valid === 1'b1) begin
      pulses++;
      if (sbq.size() == 0) begin
        check("unexpected_key_valid", {31'b0, key_valid}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("key_code", {28'b0, key_code}, {28'b0, mon_e.code});
        check("entry_data", {16'b0, entry_data}, {16'b0, mon_e.entry});
      end
    end
  end

  task automatic do_reset();
    clr = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    clr = 1'b0;
  endtask

  // Wait (bounded) until col_out equals / differs from want
  task automatic wait_col(input logic [3:0] want, input logic eq, input string name);
    int n = 0;
    while (((col_out == want) != eq) && n < 8 * SCAN_DIV) begin
      @(negedge CLK);
      n++;
    end
    check(name, {31'b0, (col_out == want)}, {31'b0, eq});
  endtask

  // Press a key, commit it on a predicted sample point, hold, release, debounce release
  task automatic run_vec(input int i);
    vec_t v;
    sb_t  e;
    logic [3:0] tgt;
    int p0;
    v   = vecs[i];
    tgt = ~(4'b0001 << v.code[1:0]);
    wait_col(tgt, 1'b0, "col_away");
    pressed[v.code] = 1'b1;
    e.code  = v.code;
    e.entry = v.exp_entry;
    sbq.push_back(e);
    p0 = pulses;
    wait_col(tgt, 1'b1, "col_reach");
    repeat (COMMIT_WAIT) @(negedge CLK);
    check("no_early_pulse", pulses - p0, 32'd0);
    entry_clr = v.do_clr;
    @(negedge CLK);
    entry_clr = 1'b0;
    check("commit_pulse", {31'b0, key_valid}, 32'd1);
    pressed = pressed | v.extra;
    repeat (3 * SCAN_DIV * DEBOUNCE) @(negedge CLK);
    pressed = 16'h0000;
    repeat ((DEBOUNCE + 2) * SCAN_DIV) @(negedge CLK);
    check("one_pulse", pulses - p0, 32'd1);
  endtask

  initial begin
    int p0;
    logic [3:0] exp_col;

    //         code   clr   extra     entry after commit
    vecs[0]  = '{4'h9, 1'b0, 16'h0000, 16'h0009};
    vecs[1]  = '{4'h1, 1'b0, 16'h0000, 16'h0091};
    vecs[2]  = '{4'hA, 1'b0, 16'h0004, 16'h091A};  // key 2 (same column) joins during hold
    vecs[3]  = '{4'h9, 1'b0, 16'h0000, 16'h91A9};
    vecs[4]  = '{4'hB, 1'b0, 16'h0000, 16'h1A9B};
    vecs[5]  = '{4'h3, 1'b0, 16'h0000, 16'hA9B3};
    vecs[6]  = '{4'h5, 1'b1, 16'h0000, 16'h0005};  // entry_clr on the commit cycle
    vecs[7]  = '{4'h7, 1'b0, 16'h0000, 16'h0057};
    vecs[8]  = '{4'hC, 1'b0, 16'h0000, 16'h057C};
    vecs[9]  = '{4'hF, 1'b0, 16'h0000, 16'h57CF};
    vecs[10] = '{4'h0, 1'b0, 16'h0000, 16'h7CF0};
    vecs[11] = '{4'hD, 1'b0, 16'h0000, 16'h000D};  // after the resets below

    clr       = 1'b1;
    entry_clr = 1'b0;
    pressed   = 16'h0000;
    repeat (3) @(negedge CLK);
    do_reset();

    // Reset values
    check("rst_col_out", {28'b0, col_out}, 32'h0000_000E);
    check("rst_key_valid", {31'b0, key_valid}, 32'd0);
    check("rst_key_code", {28'b0, key_code}, 32'd0);
    check("rst_entry_data", {16'b0, entry_data}, 32'd0);

    // Idle scan: each column held for SCAN_DIV cycles, no pulses
    for (int j = 0; j < 200; j++) begin
      exp_col = ~(4'b0001 << ((j / SCAN_DIV) % 4));
      check("idle_col", {28'b0, col_out}, {28'b0, exp_col});
      @(negedge CLK);
    end
    check("idle_no_pulse", pulses, 32'd0);

    for (int i = 0; i < NVEC - 1; i++) begin
      run_vec(i);
    end

    // clr after two matching samples aborts the press
    wait_col(4'b1110, 1'b0, "rst_col_away");
    pressed[4] = 1'b1;
    p0 = pulses;
    wait_col(4'b1110, 1'b1, "rst_col_reach");
    repeat (2 * SCAN_DIV + 3) @(negedge CLK);
    clr     = 1'b1;
    pressed = 16'h0000;
    @(negedge CLK);
    clr = 1'b0;
    check("clr_col_out", {28'b0, col_out}, 32'h0000_000E);
    check("clr_key_valid", {31'b0, key_valid}, 32'd0);
    check("clr_key_code", {28'b0, key_code}, 32'd0);
    check("clr_entry_data", {16'b0, entry_data}, 32'd0);
    repeat (SCAN_DIV - 2) @(negedge CLK);
    check("clr_col_dwell", {28'b0, col_out}, 32'h0000_000E);
    repeat (4 * SCAN_DIV * DEBOUNCE) @(negedge CLK);
    check("clr_no_pulse", pulses - p0, 32'd0);

    // Bounce: key (0,0) seen on two samples then released
    pressed = 16'h0001;
    do_reset();
    p0 = pulses;
    repeat (2 * SCAN_DIV) @(negedge CLK);
    pressed = 16'h0000;
    repeat (SCAN_DIV - 1) @(negedge CLK);
    check("bounce_col_hold", {28'b0, col_out}, 32'h0000_000E);
    @(negedge CLK);
    check("bounce_col_next", {28'b0, col_out}, 32'h0000_000D);
    repeat (4 * SCAN_DIV * DEBOUNCE) @(negedge CLK);
    check("bounce_no_pulse", pulses - p0, 32'd0);

    // Ghosting: keys 2 and E share column 2
    p0 = pulses;
    pressed = 16'h4004;
    repeat (6 * SCAN_DIV * DEBOUNCE) @(negedge CLK);
    check("ghost_no_pulse", pulses - p0, 32'd0);
    pressed = 16'h0000;
    repeat (2 * SCAN_DIV) @(negedge CLK);

    // Recovery after the corner cases
    run_vec(NVEC - 1);

    check("sb_empty", sbq.size(), 32'd0);
    check("total_pulses", pulses, NVEC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
